// File: rtl/multi_phase_light_controller.sv
// N-phase green/yellow/all-red sequencer with one-hot priority, maintenance override and illegal-state recovery.
// Optional build macro MLC_MAINT_FLASH_EN: flashing yellow on all phases while in maintenance.
module multi_phase_light_controller #(
  parameter int NUM_PHASES   = 4,
  parameter int GREEN_TICKS  = 10,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 2,
  parameter int PRIO_EXTEND  = 5,
  parameter int CNT_W        = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PHASES-1:0]         phase_priority,
  input  logic                          maintenance,
  output logic [NUM_PHASES-1:0]         green,
  output logic [NUM_PHASES-1:0]         yellow,
  output logic [NUM_PHASES-1:0]         red,
  output logic [$clog2(NUM_PHASES)-1:0] active_phase,
  output logic                          phase_done,
  output logic                          fault
);

  localparam int PW = $clog2(NUM_PHASES);
  localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] PRIO_LOAD   = CNT_W'(GREEN_TICKS + PRIO_EXTEND - 1);
  localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [PW-1:0]    LAST_PHASE  = PW'(NUM_PHASES - 1);

  typedef enum logic [2:0] {
    GREEN  = 3'd0,
    YELLOW = 3'd1,
    ALLRED = 3'd2,
    MAINT  = 3'd3
  } state_e;

  // Held as a raw vector so codes 4..7 stay representable and can be detected as illegal.
  logic [2:0]            state_q;
  state_e                state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]         next_phase_q, next_phase_d;
  logic [PW-1:0]         active_q, active_d;
  logic                  fault_q, fault_d;
  logic                  done_q, done_d;
  logic [NUM_PHASES-1:0] green_q, green_d;
  logic [NUM_PHASES-1:0] yellow_q, yellow_d;
  logic [NUM_PHASES-1:0] red_q, red_d;

  logic                  prio_valid;
  logic [PW-1:0]         prio_idx;
  logic [PW-1:0]         phase_inc;
  logic                  state_legal;

`ifdef MLC_MAINT_FLASH_EN
  logic [2:0]            flash_cnt_q, flash_cnt_d;
  logic                  flash_on_q, flash_on_d;
`endif

  always_comb begin : prio_decode
    prio_valid = $onehot(phase_priority);
    prio_idx   = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (phase_priority[i]) prio_idx = PW'(i);
    end
  end

  assign phase_inc   = (active_q == LAST_PHASE) ? '0 : active_q + PW'(1);
  assign state_legal = (state_q == GREEN) || (state_q == YELLOW) ||
                       (state_q == ALLRED) || (state_q == MAINT);

  always_comb begin : next_state
    state_d      = ALLRED;
    cnt_d        = cnt_q - CNT_W'(1);
    next_phase_d = next_phase_q;
    active_d     = active_q;
    fault_d      = fault_q;
    done_d       = 1'b0;
    if (!state_legal) begin
      cnt_d        = ALLRED_LOAD;
      fault_d      = 1'b1;
      next_phase_d = '0;
    end else if (maintenance) begin
      // Maintenance beats a simultaneous expiry; an interrupted phase counts as served.
      state_d = MAINT;
      cnt_d   = cnt_q;
      if ((state_q == GREEN) || (state_q == YELLOW)) next_phase_d = phase_inc;
    end else begin
      case (state_q)
        GREEN: begin
          state_d = GREEN;
          if (cnt_q == '0) begin
            state_d = YELLOW;
            cnt_d   = YELLOW_LOAD;
          end
        end
        YELLOW: begin
          state_d = YELLOW;
          if (cnt_q == '0) begin
            state_d      = ALLRED;
            cnt_d        = ALLRED_LOAD;
            done_d       = 1'b1;
            next_phase_d = phase_inc;
          end
        end
        ALLRED: begin
          state_d = ALLRED;
          if (cnt_q == '0) begin
            state_d  = GREEN;
            active_d = prio_valid ? prio_idx : next_phase_q;
            cnt_d    = prio_valid ? PRIO_LOAD : GREEN_LOAD;
          end
        end
        MAINT: begin
          state_d = ALLRED;
          cnt_d   = ALLRED_LOAD;
        end
        default: begin
          state_d = ALLRED;
          cnt_d   = ALLRED_LOAD;
        end
      endcase
    end
  end

`ifdef MLC_MAINT_FLASH_EN
  always_comb begin : flash_next
    flash_cnt_d = '0;
    flash_on_d  = 1'b1;
    if (state_q == MAINT) begin
      flash_cnt_d = flash_cnt_q + 3'd1;
      flash_on_d  = (flash_cnt_q == 3'd7) ? ~flash_on_q : flash_on_q;
    end
  end
`endif

  // Lamps are decoded from the upcoming state so the registered outputs line up with state_q.
  always_comb begin : lamp_decode
    green_d  = '0;
    yellow_d = '0;
    red_d    = '1;
    case (state_d)
      GREEN: begin
        green_d[active_d] = 1'b1;
        red_d[active_d]   = 1'b0;
      end
      YELLOW: begin
        yellow_d[active_d] = 1'b1;
        red_d[active_d]    = 1'b0;
      end
      MAINT: begin
`ifdef MLC_MAINT_FLASH_EN
        red_d    = '0;
        yellow_d = {NUM_PHASES{flash_on_d}};
`endif
      end
      default: begin
        red_d = '1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ALLRED;
      cnt_q        <= ALLRED_LOAD;
      next_phase_q <= '0;
      active_q     <= '0;
      fault_q      <= 1'b0;
      done_q       <= 1'b0;
      green_q      <= '0;
      yellow_q     <= '0;
      red_q        <= '1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      next_phase_q <= next_phase_d;
      active_q     <= active_d;
      fault_q      <= fault_d;
      done_q       <= done_d;
      green_q      <= green_d;
      yellow_q     <= yellow_d;
      red_q        <= red_d;
    end
  end

`ifdef MLC_MAINT_FLASH_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flash_cnt_q <= '0;
      flash_on_q  <= 1'b1;
    end else begin
      flash_cnt_q <= flash_cnt_d;
      flash_on_q  <= flash_on_d;
    end
  end
`endif

  assign green        = green_q;
  assign yellow       = yellow_q;
  assign red          = red_q;
  assign active_phase = active_q;
  assign phase_done   = done_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_multi_phase_light_controller.sv
// Randomized bench for multi_phase_light_controller: expected lamp frames are built from the phase rules
// (durations, rotation, priority) and compared once per clock; maintenance and fault scenarios use frame arithmetic.
module tb_multi_phase_light_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] phase_priority = 4'b0000;
  logic       maintenance = 1'b0;
  logic [3:0] green, yellow, red;
  logic [1:0] active_phase;
  logic       phase_done, fault;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] g;
    logic [3:0] y;
    logic [3:0] r;
    logic [1:0] act;
    logic       done;
  } frame_t;

  frame_t     exp_q[$];
  logic [3:0] drv_q[$];
  logic [3:0] serve_prio[$];

  multi_phase_light_controller dut (
    .clk            (clk),
    .rst            (rst),
    .phase_priority (phase_priority),
    .maintenance    (maintenance),
    .green          (green),
    .yellow         (yellow),
    .red            (red),
    .active_phase   (active_phase),
    .phase_done     (phase_done),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  // kind: 0 green, 1 yellow, 2 all red
  function automatic frame_t mk(input int kind, input int ph, input logic d);
    frame_t f;
    f.g = '0; f.y = '0; f.r = '1; f.act = 2'(ph); f.done = d;
    if (kind == 0) begin f.g[ph] = 1'b1; f.r[ph] = 1'b0; end
    else if (kind == 1) begin f.y[ph] = 1'b1; f.r[ph] = 1'b0; end
    return f;
  endfunction

  function automatic frame_t mk_maint(input int ph, input int k);
    frame_t f;
    f.g = '0; f.act = 2'(ph); f.done = 1'b0;
`ifdef MLC_MAINT_FLASH_EN
    f.r = '0;
    f.y = (((k / 8) % 2) == 0) ? 4'b1111 : 4'b0000;
`else
    f.r = '1;
    f.y = '0;
    if (k < 0) f.y = '1;
`endif
    return f;
  endfunction

  function automatic int prio_phase(input logic [3:0] p);
    if ($countones(p) != 1) return -1;
    for (int i = 0; i < 4; i++) if (p[i]) return i;
    return -1;
  endfunction

  // Expected frame list after reset release: two all-red frames, then one block per serve.
  // Priority for serve k+1 is applied during serve k's green, after its own decision was taken.
  task automatic build_model();
    int nxt;
    logic [3:0] drv;
    exp_q.delete();
    drv_q.delete();
    nxt = 0;
    drv = serve_prio[0];
    repeat (2) begin exp_q.push_back(mk(2, 0, 1'b0)); drv_q.push_back(drv); end
    for (int k = 0; k < serve_prio.size(); k++) begin
      int pp, ph, glen;
      pp   = prio_phase(serve_prio[k]);
      ph   = (pp >= 0) ? pp : nxt;
      glen = 10 + ((pp >= 0) ? 5 : 0);
      for (int i = 0; i < glen; i++) begin
        if (i == 3 && k + 1 < serve_prio.size()) drv = serve_prio[k+1];
        exp_q.push_back(mk(0, ph, 1'b0)); drv_q.push_back(drv);
      end
      repeat (3) begin exp_q.push_back(mk(1, ph, 1'b0)); drv_q.push_back(drv); end
      exp_q.push_back(mk(2, ph, 1'b1)); drv_q.push_back(drv);
      exp_q.push_back(mk(2, ph, 1'b0)); drv_q.push_back(drv);
      nxt = (ph + 1) % 4;
    end
  endtask

  task automatic do_reset(input logic [3:0] p);
    rst = 1'b0;
    maintenance = 1'b0;
    phase_priority = p;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    phase_priority = '0;
    maintenance = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (red !== 4'b1111) begin errors++; $display("FAIL reset_red: got %b required 1111", red); end
    checks++; if ((green | yellow) !== 4'b0000) begin errors++; $display("FAIL reset_gy: got g=%b y=%b required 0000", green, yellow); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b required 0", fault); end
    checks++; if (active_phase !== 2'd0) begin errors++; $display("FAIL reset_active: got %0d required 0", active_phase); end
    checks++; if (phase_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", phase_done); end
    $display("test_reset done");
  endtask

  task automatic test_rotation();
    serve_prio = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    build_model();
    do_reset(drv_q[0]);
    for (int f = 0; f < exp_q.size(); f++) begin
      phase_priority = drv_q[f];
      checks++;
      if ({green, yellow, red, active_phase, phase_done} !== exp_q[f]) begin
        errors++;
        $display("FAIL rotation frame %0d: got g=%b y=%b r=%b act=%0d done=%b required %b", f,
                 green, yellow, red, active_phase, phase_done, exp_q[f]);
      end
      @(negedge clk);
    end
    $display("test_rotation done: %0d frames", exp_q.size());
  endtask

  task automatic test_priority_hold();
    serve_prio = '{4'b0100, 4'b0100, 4'b0000};
    build_model();
    do_reset(drv_q[0]);
    for (int f = 0; f < exp_q.size(); f++) begin
      phase_priority = drv_q[f];
      checks++;
      if ({green, yellow, red, active_phase, phase_done} !== exp_q[f]) begin
        errors++;
        $display("FAIL priority_hold frame %0d: got g=%b y=%b r=%b act=%0d done=%b required %b", f,
                 green, yellow, red, active_phase, phase_done, exp_q[f]);
      end
      @(negedge clk);
    end
    $display("test_priority_hold done: %0d frames", exp_q.size());
  endtask

  task automatic test_multihot();
    serve_prio = '{4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110};
    build_model();
    do_reset(drv_q[0]);
    for (int f = 0; f < exp_q.size(); f++) begin
      phase_priority = drv_q[f];
      checks++;
      if ({green, yellow, red, active_phase, phase_done} !== exp_q[f]) begin
        errors++;
        $display("FAIL multihot frame %0d: got g=%b y=%b r=%b act=%0d done=%b required %b", f,
                 green, yellow, red, active_phase, phase_done, exp_q[f]);
      end
      @(negedge clk);
    end
    $display("test_multihot done: %0d frames", exp_q.size());
  endtask

  task automatic test_random_priority();
    serve_prio.delete();
    for (int k = 0; k < 14; k++) begin
      int sel, a, b;
      logic [3:0] v;
      sel = int'($urandom_range(0, 2));
      a   = int'($urandom_range(0, 3));
      b   = (a + 1 + int'($urandom_range(0, 2))) % 4;
      v   = '0;
      if (sel == 1) v[a] = 1'b1;
      if (sel == 2) begin v[a] = 1'b1; v[b] = 1'b1; end
      serve_prio.push_back(v);
    end
    build_model();
    do_reset(drv_q[0]);
    for (int f = 0; f < exp_q.size(); f++) begin
      phase_priority = drv_q[f];
      checks++;
      if ({green, yellow, red, active_phase, phase_done} !== exp_q[f]) begin
        errors++;
        $display("FAIL random_prio frame %0d: got g=%b y=%b r=%b act=%0d done=%b required %b", f,
                 green, yellow, red, active_phase, phase_done, exp_q[f]);
      end
      @(negedge clk);
    end
    $display("test_random_priority done: %0d serves, %0d frames", serve_prio.size(), exp_q.size());
  endtask

  // Maintenance held for frames 20..49, i.e. mid-green of phase 1 (green frames 17..26).
  task automatic test_maintenance();
    frame_t e;
    do_reset(4'b0000);
    for (int f = 0; f <= 60; f++) begin
      maintenance = (f >= 20 && f < 50);
      if (f < 2)        e = mk(2, 0, 1'b0);
      else if (f < 12)  e = mk(0, 0, 1'b0);
      else if (f < 15)  e = mk(1, 0, 1'b0);
      else if (f == 15) e = mk(2, 0, 1'b1);
      else if (f == 16) e = mk(2, 0, 1'b0);
      else if (f < 21)  e = mk(0, 1, 1'b0);
      else if (f < 51)  e = mk_maint(1, f - 21);
      else if (f < 53)  e = mk(2, 1, 1'b0);
      else              e = mk(0, 2, 1'b0);
      checks++;
      if ({green, yellow, red, active_phase, phase_done} !== e) begin
        errors++;
        $display("FAIL maintenance frame %0d: got g=%b y=%b r=%b act=%0d done=%b required %b", f,
                 green, yellow, red, active_phase, phase_done, e);
      end
      @(negedge clk);
    end
    maintenance = 1'b0;
    $display("test_maintenance done");
  endtask

  // Corrupts the state register during frame 5 (green of phase 0); leaves the bench at frame 25.
  task automatic test_illegal();
    frame_t e;
    do_reset(4'b0000);
    repeat (5) @(negedge clk);
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL illegal_prefault: got %b required 0", fault); end
    force dut.state_q = 3'b111;
    #1 release dut.state_q;
    @(negedge clk);
    for (int f = 6; f < 25; f++) begin
      if (f < 8)        e = mk(2, 0, 1'b0);
      else if (f < 18)  e = mk(0, 0, 1'b0);
      else if (f < 21)  e = mk(1, 0, 1'b0);
      else if (f == 21) e = mk(2, 0, 1'b1);
      else if (f == 22) e = mk(2, 0, 1'b0);
      else              e = mk(0, 1, 1'b0);
      checks++;
      if ({green, yellow, red, active_phase, phase_done} !== e) begin
        errors++;
        $display("FAIL illegal_recover frame %0d: got g=%b y=%b r=%b act=%0d done=%b required %b", f,
                 green, yellow, red, active_phase, phase_done, e);
      end
      checks++;
      if (fault !== 1'b1) begin errors++; $display("FAIL illegal_fault frame %0d: got %b required 1", f, fault); end
      @(negedge clk);
    end
    $display("test_illegal done");
  endtask

  // Continues from frame 25 of test_illegal; yellow of phase 1 occupies frames 33..35.
  task automatic test_async_reset();
    repeat (9) @(negedge clk);
    checks++; if (yellow !== 4'b0010) begin errors++; $display("FAIL async_pre_yellow: got %b required 0010", yellow); end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL async_pre_fault: got %b required 1", fault); end
    #1 rst = 1'b0;
    #1;
    checks++; if (red !== 4'b1111) begin errors++; $display("FAIL async_red: got %b required 1111", red); end
    checks++; if ((green | yellow) !== 4'b0000) begin errors++; $display("FAIL async_gy: got g=%b y=%b required 0000", green, yellow); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL async_fault: got %b required 0", fault); end
    checks++; if (active_phase !== 2'd0) begin errors++; $display("FAIL async_active: got %0d required 0", active_phase); end
    checks++; if (phase_done !== 1'b0) begin errors++; $display("FAIL async_done: got %b required 0", phase_done); end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_priority_hold();
    test_multihot();
    test_random_priority();
    test_maintenance();
    test_illegal();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_phase_light_controller.md
Name: multi_phase_light_controller

Overview:
Parametrised successor to the two-direction traffic light controller. It sequences NUM_PHASES approaches through green, yellow and all-red using an internal down-counter, so no separate timing controller is needed. Adds per-phase one-hot priority with green extension and jump-ahead, a maintenance override, and illegal-state recovery with a sticky fault flag. Sits directly under top and replaces the light and timing controllers.

Parameters:
NUM_PHASES, 4, number of approaches/phases (2..8)
GREEN_TICKS, 10, green duration in clk cycles (>=1)
YELLOW_TICKS, 3, yellow duration in clk cycles (>=1)
ALLRED_TICKS, 2, all-red clearance in clk cycles (>=1)
PRIO_EXTEND, 5, extra green cycles for the prioritised phase
CNT_W, 8, counter width; must hold GREEN_TICKS+PRIO_EXTEND-1

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
phase_priority  input  NUM_PHASES  one-hot priority request; zero or multi-hot means no priority
maintenance  input  1  maintenance override, level-sensitive
green  output  NUM_PHASES  green lamp per phase
yellow  output  NUM_PHASES  yellow lamp per phase
red  output  NUM_PHASES  red lamp per phase
active_phase  output  $clog2(NUM_PHASES)  phase currently or last served
phase_done  output  1  one-cycle pulse on the cycle the yellow-to-all-red transition is taken
fault  output  1  sticky illegal-state flag, cleared only by rst

Behaviour:
- Reset (rst=0, async):
  - state=ALLRED, cnt=ALLRED_TICKS-1, next_phase=0, active_phase=0.
  - red=all ones; green=0, yellow=0, phase_done=0, fault=0.
- States: GREEN, YELLOW, ALLRED, MAINT. Any other encoding is illegal.
- Counter: loaded with duration-1 on state entry and decremented each cycle. The transition is taken on the cycle cnt==0, so each state lasts exactly its duration.
- ALLRED->GREEN:
  - Entered phase = priority phase if phase_priority is exactly one-hot, else next_phase.
  - active_phase updates to the entered phase on entry.
- GREEN duration:
  - GREEN_TICKS, plus PRIO_EXTEND if phase_priority is one-hot on active_phase at the entry cycle.
  - Sampled once; later priority changes do not alter the running green.
- GREEN->YELLOW after its duration; YELLOW->ALLRED after YELLOW_TICKS.
  - phase_done pulses on the YELLOW->ALLRED cycle.
  - next_phase <= (active_phase+1) mod NUM_PHASES on that same cycle (wrap-around at NUM_PHASES-1).
- Outputs are registered and decoded from state/active_phase:
  - GREEN: green[active_phase]=1, all other phases red.
  - YELLOW: yellow[active_phase]=1, all other phases red.
  - ALLRED: all red.
  - Exactly one lamp per phase is lit at all times, except in MAINT with flash.
- Maintenance:
  - maintenance=1 sampled high in any state moves the block to MAINT next cycle. This overrides a simultaneous counter expiry; no phase_done pulse.
  - MAINT with flash compiled out: all red.
  - On deassert: MAINT->ALLRED with full ALLRED_TICKS, then resume at next_phase. An interrupted phase is not re-served; next_phase advances past it.
- Illegal state:
  - Next cycle forces ALLRED, loads cnt=ALLRED_TICKS-1, sets fault=1, sets next_phase=0.
  - Normal rotation resumes without reset; fault stays high until rst.
- Priority asserted mid-yellow/all-red takes effect at the next ALLRED->GREEN decision only.

Optional Feature:
MLC_MAINT_FLASH_EN
- Defined: in MAINT, yellow on all phases toggles every 8 cycles via a 3-bit flash counter cleared on MAINT entry (yellow on for the first 8 cycles); red=0, green=0.
- Undefined: MAINT drives all red, no flash counter is synthesised.
- All other behaviour is identical.

Test Plan:
- Reset, priority=0, defaults:
  - red=4'b1111 for 2 cycles after rst rises.
  - Then green[0] for 10 cycles, yellow[0] for 3, all red for 2, green[1].
  - phase_done is single-cycle each time; phase order 0,1,2,3,0 (wrap).
- phase_priority=4'b0100 held from reset:
  - The first green is phase 2 for 15 cycles.
  - After all-red, phase 2 again: jump-ahead wins over next_phase=3.
- phase_priority=4'b0110 (multi-hot): rotation identical to the no-priority case, green durations 10.
- maintenance pulsed high for 30 cycles mid-green of phase 1:
  - Next cycle all red (or yellow flash with MLC_MAINT_FLASH_EN, yellow=4'b1111 on the first MAINT cycle).
  - After deassert: 2 all-red cycles, then green[2].
- Force the state register to an illegal code via hierarchy:
  - The next cycle is all red and fault=1.
  - Green[0] follows after 2 cycles; fault remains 1 until rst.
- Assert rst low mid-yellow: outputs go all red asynchronously, fault=0, active_phase=0.
